// File: rtl/histogram_pkg.sv
// Shared definitions for the histogram save and restore paths: loader state
// encoding, byte-phase encoding and the histogram geometry constants.
package histogram_pkg;

  localparam int HIST_BINS        = 1024;
  localparam int WORDS_PER_SECTOR = 256;
  localparam int SECTOR_BYTES     = 512;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    ISSUE    = 2'd2,
    READ     = 2'd3
  } state_e;

  typedef enum logic {
    PH_MS = 1'b0,
    PH_LS = 1'b1
  } phase_e;

endpackage

// File: rtl/byte_pair_packer.sv
// Packs a byte stream into 16-bit words, first byte in the high half.
// o_valid is high for the single cycle in which the second byte arrives.
module byte_pair_packer
  import histogram_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_clear,
  input  logic        i_strobe,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_word,
  output logic        o_valid
);

  phase_e     r_phase;
  logic [7:0] r_hi;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= PH_MS;
      r_hi    <= 8'h00;
    end else if (i_clear) begin
      r_phase <= PH_MS;
    end else if (i_strobe) begin
      if (r_phase == PH_MS) begin
        r_hi    <= i_byte;
        r_phase <= PH_LS;
      end else begin
        r_phase <= PH_MS;
      end
    end
  end

  assign o_valid = i_strobe & (r_phase == PH_LS) & ~i_clear;
  assign o_word  = {r_hi, i_byte};

endmodule

// File: rtl/histogram_loader.sv
// Restores a saved 1024 x 16-bit histogram from SECTORS SD sectors into BRAM.
// Optional LOADER_CHECKSUM_EN adds checksum/csum_ok over the stored sum word.
module histogram_loader #(
  parameter int SECTORS      = 4,
  parameter int SLOT_SHIFT   = 11,
  parameter int SECTOR_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  slot,
  input  logic        sd_ready,
  output logic [31:0] sd_address,
  output logic        sd_rd,
  input  logic [7:0]  sd_dout,
  input  logic        sd_byte_available,
  output logic [9:0]  waddr,
  output logic [15:0] wdata,
  output logic        we,
  output logic        loading,
  output logic        done,
  output logic        short_err
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum,
  output logic        csum_ok
`endif
);

  import histogram_pkg::state_e;
  import histogram_pkg::IDLE;
  import histogram_pkg::WAIT_RDY;
  import histogram_pkg::ISSUE;
  import histogram_pkg::READ;

  localparam int CNT_W = $clog2(SECTOR_BYTES + 1);
  localparam int SEC_W = (SECTORS > 1) ? $clog2(SECTORS) : 1;
  localparam int WORDS = SECTOR_BYTES / 2;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SECTOR_BYTES);
  localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(SECTORS - 1);

  state_e           r_state;
  logic [31:0]      r_sd_address;
  logic             r_sd_rd;
  logic [9:0]       r_waddr;
  logic [15:0]      r_wdata;
  logic             r_we;
  logic             r_loading;
  logic             r_done;
  logic             r_short_err;
  logic [SEC_W-1:0] r_sector;
  logic [CNT_W-1:0] r_byte_cnt;
  logic             r_last_avail;

  logic             w_strobe;
  logic             w_take;
  logic             w_pack_clear;
  logic             w_word_valid;
  logic [15:0]      w_word;
  logic             w_accept_start;
  logic             w_sector_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_last_avail <= 1'b0;
    else          r_last_avail <= sd_byte_available;
  end

  assign w_strobe       = sd_byte_available & ~r_last_avail;
  assign w_take         = (r_state == READ) && w_strobe && (r_byte_cnt < FULL_CNT);
  assign w_pack_clear   = (r_state == WAIT_RDY) && sd_ready;
  assign w_accept_start = (r_state == IDLE) && start;

  // A sector closes only once no byte is arriving and no write is in flight,
  // so the final byte is counted and its write still lands inside READ.
  assign w_sector_end   = (r_state == READ) && sd_ready && !w_take && !r_we;

  byte_pair_packer u_packer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_pack_clear),
    .i_strobe (w_take),
    .i_byte   (sd_dout),
    .o_word   (w_word),
    .o_valid  (w_word_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_sd_address <= 32'h0;
      r_sd_rd      <= 1'b0;
      r_waddr      <= 10'h0;
      r_wdata      <= 16'h0;
      r_we         <= 1'b0;
      r_loading    <= 1'b0;
      r_done       <= 1'b0;
      r_short_err  <= 1'b0;
      r_sector     <= '0;
      r_byte_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      r_we   <= w_word_valid;
      if (w_word_valid) r_wdata    <= w_word;
      if (r_we)         r_waddr    <= r_waddr + 10'd1;
      if (w_take)       r_byte_cnt <= r_byte_cnt + CNT_W'(1);

      case (r_state)
        IDLE: begin
          if (start) begin
            r_sd_address <= 32'(slot) << SLOT_SHIFT;
            r_sector     <= '0;
            r_waddr      <= 10'h0;
            r_short_err  <= 1'b0;
            r_byte_cnt   <= '0;
            r_loading    <= 1'b1;
            r_state      <= WAIT_RDY;
          end
        end

        WAIT_RDY: begin
          if (sd_ready) begin
            r_sd_rd <= 1'b1;
            r_state <= ISSUE;
          end
        end

        ISSUE: begin
          if (!sd_ready) begin
            r_sd_rd <= 1'b0;
            r_state <= READ;
          end
        end

        READ: begin
          if (w_sector_end) begin
            if (r_byte_cnt != FULL_CNT) r_short_err <= 1'b1;
            if (r_sector == LAST_SEC) begin
              r_loading <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= IDLE;
            end else begin
              // Realign to the next sector base even if this one came up short.
              r_sector     <= r_sector + SEC_W'(1);
              r_sd_address <= r_sd_address + 32'(SECTOR_BYTES);
              r_waddr      <= 10'((int'(r_sector) + 1) * WORDS);
              r_byte_cnt   <= '0;
              r_state      <= WAIT_RDY;
            end
          end
        end

        default: begin
          r_sd_rd   <= 1'b0;
          r_loading <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign sd_address = r_sd_address;
  assign sd_rd      = r_sd_rd;
  assign waddr      = r_waddr;
  assign wdata      = r_wdata;
  assign we         = r_we;
  assign loading    = r_loading;
  assign done       = r_done;
  assign short_err  = r_short_err;

`ifdef LOADER_CHECKSUM_EN
  localparam logic [9:0] LAST_BIN = 10'(SECTORS * WORDS - 1);

  logic [15:0] r_csum;
  logic [15:0] r_stored;
  logic        r_csum_ok;

  // The final bin carries the saved sum, so it is captured rather than summed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_csum    <= 16'h0;
      r_stored  <= 16'h0;
      r_csum_ok <= 1'b0;
    end else begin
      if (w_accept_start) begin
        r_csum    <= 16'h0;
        r_stored  <= 16'h0;
        r_csum_ok <= 1'b0;
      end else if (r_we) begin
        if (r_waddr == LAST_BIN) r_stored <= r_wdata;
        else                     r_csum   <= r_csum + r_wdata;
      end
      if (w_sector_end && (r_sector == LAST_SEC)) r_csum_ok <= (r_csum == r_stored);
    end
  end

  assign checksum = r_csum;
  assign csum_ok  = r_csum_ok;
`endif

endmodule
